sram_uart_bus: RTL and testbench

//  Physical bus controller directly downstream of mem_control in the 16-bit THCO-MIPS core.

---
 rtl/sram_uart_bus.sv | 152 +++++++++++++++
 tb/tb_sram_uart_bus.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sram_uart_bus.sv
// sram_uart_bus
//    Physical bus controller that sits after mem_control in the 16-bit
//    THCO-MIPS core. It takes one arbitrated request at a time and runs it
//    on the board SRAM pins or on the UART that shares the RAM1 data bus.
//
// Ports
//    clk, rst            system clock; asynchronous active-low reset
//    memAddress_i        request address (latched on acceptance)
//    memDataWrite_i      request write data (latched on acceptance)
//    memReadEnable_i     read request
//    memWriteEnable_i    write request (has priority over a read)
//    memDataRead_o       read result, valid with memDone_o, held until the next read
//    memDone_o           one-cycle pulse when the request finishes
//    memBusy_o           high whenever the controller is not idle
//    ramAddr_o           SRAM address {RAM_BANK, latched address}
//    ramData_io          shared SRAM/UART data bus
//    ramEN_o/OE_o/WE_o   SRAM strobes, active-low
//    uartRdn_o/Wrn_o     UART strobes, active-low
//    uartDataReady_i, uartTbre_i, uartTsre_i   UART status, active-high
//    stateDbg_o          current FSM state, for debug and checkers
//
// Handshake: a request is taken only in IDLE, on any rising edge where a
// read or write enable is high. The requester keeps the request asserted
// until memDone_o. The controller ignores request inputs while memBusy_o is high.
module sram_uart_bus #(
   parameter logic [1:0]  RAM_BANK       = 2'b00,
   parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
   parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] memAddress_i,
   input  logic [15:0] memDataWrite_i,
   input  logic        memReadEnable_i,
   input  logic        memWriteEnable_i,
   output logic [15:0] memDataRead_o,
   output logic        memDone_o,
   output logic        memBusy_o,
   output logic [17:0] ramAddr_o,
   inout  wire  [15:0] ramData_io,
   output logic        ramEN_o,
   output logic        ramOE_o,
   output logic        ramWE_o,
   output logic        uartRdn_o,
   output logic        uartWrn_o,
   input  logic        uartDataReady_i,
   input  logic        uartTbre_i,
   input  logic        uartTsre_i,
   output logic [3:0]  stateDbg_o
);

   typedef enum logic [3:0] {
      IDLE, RRD, WSET, WSTB, WHLD, URD, UWR, UTBRE, UTSRE, DONE
   } stateT;

   stateT       state, nextState;
   logic [15:0] addrQ, dataQ, readQ;
   logic        statusRead;
   logic        driveQ;
   logic        isUartData, isUartStat, accept;
   logic [15:0] statusLive;

   assign isUartData = (memAddress_i == UART_DATA_ADDR);
   assign isUartStat = (memAddress_i == UART_STAT_ADDR);
   assign accept     = (state == IDLE) && (memReadEnable_i || memWriteEnable_i);
   assign statusLive = {14'b0, uartDataReady_i, uartTbre_i & uartTsre_i};

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (memWriteEnable_i) begin
               // A write to the status register has no effect; it just completes.
               if (isUartData)      nextState = UWR;
               else if (isUartStat) nextState = DONE;
               else                 nextState = WSET;
            end else if (memReadEnable_i) begin
               if (isUartData)      nextState = URD;
               else if (isUartStat) nextState = DONE;
               else                 nextState = RRD;
            end
         end
         RRD:     nextState = DONE;
         WSET:    nextState = WSTB;
         WSTB:    nextState = WHLD;
         WHLD:    nextState = DONE;
         URD:     nextState = DONE;
         UWR:     nextState = UTBRE;
         UTBRE:   if (uartTbre_i) nextState = UTSRE;
         UTSRE:   if (uartTsre_i) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   // Strobes are registered decodes of the next state. The pins then come
   // straight from flops, so they are glitch-free. They also track the
   // state register exactly, and reset drives them high at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ramEN_o   <= 1'b1;
         ramOE_o   <= 1'b1;
         ramWE_o   <= 1'b1;
         uartRdn_o <= 1'b1;
         uartWrn_o <= 1'b1;
         driveQ    <= 1'b0;
         memDone_o <= 1'b0;
      end else begin
         ramEN_o   <= !(nextState inside {RRD, WSET, WSTB, WHLD});
         ramOE_o   <= (nextState != RRD);
         ramWE_o   <= (nextState != WSTB);
         uartRdn_o <= (nextState != URD);
         uartWrn_o <= (nextState != UWR);
         driveQ    <= (nextState inside {WSET, WSTB, WHLD, UWR});
         memDone_o <= (nextState == DONE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addrQ      <= '0;
         dataQ      <= '0;
         readQ      <= '0;
         statusRead <= 1'b0;
      end else begin
         if (accept) begin
            addrQ      <= memAddress_i;
            dataQ      <= memDataWrite_i;
            statusRead <= !memWriteEnable_i && isUartStat;
         end
         // Capture the bus at the end of a read strobe cycle.
         if (state == RRD || state == URD)
            readQ <= ramData_io;
         else if (state == DONE && statusRead)
            readQ <= statusLive;
      end
   end

   // A status read shows live status during DONE. The value captured at
   // the end of DONE holds it afterwards.
   assign memDataRead_o = (state == DONE && statusRead) ? statusLive : readQ;
   assign memBusy_o     = (state != IDLE);
   assign ramAddr_o     = {RAM_BANK, addrQ};
   assign ramData_io    = driveQ ? dataQ : 16'hzzzz;
   assign stateDbg_o    = state;

endmodule

// File: tb/tb_sram_uart_bus.sv
module tb_sram_uart_bus;

   localparam logic [15:0] UART_RX = 16'h00A5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] memAddress_i = '0;
   logic [15:0] memDataWrite_i = '0;
   logic        memReadEnable_i = 1'b0;
   logic        memWriteEnable_i = 1'b0;
   logic [15:0] memDataRead_o;
   logic        memDone_o, memBusy_o;
   logic [17:0] ramAddr_o;
   wire  [15:0] ramData_io;
   logic        ramEN_o, ramOE_o, ramWE_o, uartRdn_o, uartWrn_o;
   logic        uartDataReady_i = 1'b0;
   logic        uartTbre_i = 1'b1;
   logic        uartTsre_i = 1'b1;
   logic [3:0]  stateDbg_o;

   sram_uart_bus dut (
      .clk(clk), .rst(rst),
      .memAddress_i(memAddress_i), .memDataWrite_i(memDataWrite_i),
      .memReadEnable_i(memReadEnable_i), .memWriteEnable_i(memWriteEnable_i),
      .memDataRead_o(memDataRead_o), .memDone_o(memDone_o), .memBusy_o(memBusy_o),
      .ramAddr_o(ramAddr_o), .ramData_io(ramData_io),
      .ramEN_o(ramEN_o), .ramOE_o(ramOE_o), .ramWE_o(ramWE_o),
      .uartRdn_o(uartRdn_o), .uartWrn_o(uartWrn_o),
      .uartDataReady_i(uartDataReady_i), .uartTbre_i(uartTbre_i), .uartTsre_i(uartTsre_i),
      .stateDbg_o(stateDbg_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   // SRAM and UART models on the shared bus
   logic [15:0] sram [0:255];
   assign ramData_io = (!ramEN_o && !ramOE_o) ? sram[ramAddr_o[7:0]] :
                       (!uartRdn_o ? UART_RX : 16'hzzzz);
   always @(posedge ramWE_o) begin
      if (rst && !ramEN_o) sram[ramAddr_o[7:0]] = ramData_io;
   end

   // scoreboard
   int passCount = 0;
   int checkCount = 0;
   logic [15:0] expQ [$];

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // per-cycle logs; index k is cycle N+k after the accepting edge N
   logic        weLog [1:16], oeLog [1:16], enLog [1:16], rdnLog [1:16], wrnLog [1:16];
   logic        doneLog [1:16], busyLog [1:16];
   logic [15:0] busLog [1:16], rdLog [1:16];
   logic [17:0] addrLog [1:16];
   int          doneAt, doneCnt;

   function automatic logic [15:0] pat(input logic a [1:16], input int n);
      pat = '0;
      for (int k = 1; k <= n; k++) pat[k-1] = a[k];
   endfunction

   // driver
   task automatic runReq(input logic [15:0] addr, input logic [15:0] data,
                         input logic rd, input logic wr,
                         input int nCyc, input int tbreAt, input int tsreAt);
      @(negedge clk);
      memAddress_i = addr; memDataWrite_i = data;
      memReadEnable_i = rd; memWriteEnable_i = wr;
      @(posedge clk);
      doneAt = 0; doneCnt = 0;
      for (int k = 1; k <= nCyc; k++) begin
         @(negedge clk);
         if (k == 1) begin memReadEnable_i = 1'b0; memWriteEnable_i = 1'b0; end
         weLog[k] = ramWE_o;   oeLog[k] = ramOE_o;   enLog[k] = ramEN_o;
         rdnLog[k] = uartRdn_o; wrnLog[k] = uartWrn_o;
         doneLog[k] = memDone_o; busyLog[k] = memBusy_o;
         busLog[k] = ramData_io; rdLog[k] = memDataRead_o; addrLog[k] = ramAddr_o;
         if (memDone_o) begin doneCnt++; if (doneAt == 0) doneAt = k; end
         if (k == tbreAt) uartTbre_i = 1'b1;
         if (k == tsreAt) uartTsre_i = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int busyBad;
      for (int i = 0; i < 256; i++) sram[i] = '0;

      // reset state
      #12;
      checkVal("reset strobes/busy/done",
               {ramEN_o, ramOE_o, ramWE_o, uartRdn_o, uartWrn_o, memBusy_o, memDone_o}, 7'b1111100);
      checkVal("reset ramAddr", ramAddr_o, 18'h0);
      checkVal("reset readData", memDataRead_o, 16'h0);
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: RAM write 1234 -> 0040
      runReq(16'h0040, 16'h1234, 1'b0, 1'b1, 5, 0, 0);
      checkVal("t1 ramAddr", addrLog[2], 18'h00040);
      checkVal("t1 WE pattern", pat(weLog, 5), 5'b11101);
      checkVal("t1 EN pattern", pat(enLog, 5), 5'b11000);
      checkVal("t1 bus N+1", busLog[1], 16'h1234);
      checkVal("t1 bus N+2", busLog[2], 16'h1234);
      checkVal("t1 bus N+3", busLog[3], 16'h1234);
      checkVal("t1 done pattern", pat(doneLog, 5), 5'b01000);
      checkVal("t1 busy pattern", pat(busyLog, 5), 5'b01111);
      checkVal("t1 sram content", sram[8'h40], 16'h1234);

      // 2: RAM read 0040
      expQ.push_back(16'h1234);
      runReq(16'h0040, 16'h5A5A, 1'b1, 1'b0, 3, 0, 0);
      checkVal("t2 OE pattern", pat(oeLog, 3), 3'b110);
      checkVal("t2 WE pattern", pat(weLog, 3), 3'b111);
      checkVal("t2 bus during RRD", busLog[1], 16'h1234);
      checkVal("t2 done pattern", pat(doneLog, 3), 3'b010);
      checkVal("t2 readData", rdLog[2], expQ.pop_front());

      // 3: status reads
      uartDataReady_i = 1'b0; uartTbre_i = 1'b1; uartTsre_i = 1'b1;
      runReq(16'hBF01, 16'h0000, 1'b1, 1'b0, 2, 0, 0);
      checkVal("t3a done pattern", pat(doneLog, 2), 2'b01);
      checkVal("t3a status", rdLog[1], 16'h0001);
      checkVal("t3a status held", rdLog[2], 16'h0001);
      checkVal("t3a EN pattern", pat(enLog, 2), 2'b11);
      uartDataReady_i = 1'b1; uartTbre_i = 1'b0;
      runReq(16'hBF01, 16'h0000, 1'b1, 1'b0, 2, 0, 0);
      checkVal("t3b done pattern", pat(doneLog, 2), 2'b01);
      checkVal("t3b status", rdLog[1], 16'h0002);
      checkVal("t3b status held", rdLog[2], 16'h0002);

      // UART data read
      uartTbre_i = 1'b1;
      runReq(16'hBF00, 16'h0000, 1'b1, 1'b0, 3, 0, 0);
      checkVal("uart rd rdn pattern", pat(rdnLog, 3), 3'b110);
      checkVal("uart rd EN pattern", pat(enLog, 3), 3'b111);
      checkVal("uart rd done pattern", pat(doneLog, 3), 3'b010);
      checkVal("uart rd data", rdLog[2], UART_RX);

      // 4: UART write with delayed tbre/tsre
      uartTbre_i = 1'b0; uartTsre_i = 1'b0;
      runReq(16'hBF00, 16'h0041, 1'b0, 1'b1, 12, 6, 9);
      checkVal("t4 wrn pattern", pat(wrnLog, 12), 12'hFFE);
      checkVal("t4 EN pattern", pat(enLog, 12), 12'hFFF);
      checkVal("t4 bus at wrn", busLog[1], 16'h0041);
      checkVal("t4 busy pattern", pat(busyLog, 12), 12'h3FF);
      checkVal("t4 done cycle", doneAt, 10);
      checkVal("t4 done count", doneCnt, 1);

      // 6: read+write together -> write wins
      runReq(16'h0010, 16'hBEEF, 1'b1, 1'b1, 5, 0, 0);
      checkVal("t6 WE pattern", pat(weLog, 5), 5'b11101);
      checkVal("t6 OE pattern", pat(oeLog, 5), 5'b11111);
      checkVal("t6 done pattern", pat(doneLog, 5), 5'b01000);
      checkVal("t6 readData unchanged", rdLog[4], UART_RX);
      checkVal("t6 sram content", sram[8'h10], 16'hBEEF);

      // 5: async reset during WSTB
      @(negedge clk);
      memAddress_i = 16'h0020; memDataWrite_i = 16'hCAFE; memWriteEnable_i = 1'b1;
      @(posedge clk);
      @(negedge clk); memWriteEnable_i = 1'b0;
      @(negedge clk);
      checkVal("t5 WE low in WSTB", ramWE_o, 1'b0);
      #1 rst = 1'b0;
      #1;
      checkVal("t5 strobes after reset", {ramEN_o, ramOE_o, ramWE_o}, 3'b111);
      checkVal("t5 busy/done after reset", {memBusy_o, memDone_o}, 2'b00);
      checkVal("t5 readData cleared", memDataRead_o, 16'h0);
      @(negedge clk); rst = 1'b1;
      busyBad = 0;
      repeat (3) begin
         @(negedge clk);
         if (memBusy_o || memDone_o) busyBad++;
      end
      checkVal("t5 idle after release", busyBad, 0);

      // recovery read
      runReq(16'h0040, 16'h0000, 1'b1, 1'b0, 3, 0, 0);
      checkVal("post-reset done pattern", pat(doneLog, 3), 3'b010);
      checkVal("post-reset readData", rdLog[2], 16'h1234);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
